// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arb_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned OP_W   = 6;

    // ALU keeps its previous ans_ex under this opcode
    localparam logic [OP_W-1:0] HOLD_OP = 6'b010000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] din;
    } alu_req_t;

endpackage

// File: rtl/alu_req_arbiter_rr_arb2.sv
// Two-input round-robin grant: a lone request wins; on a tie the requester
// that was not granted last wins. Purely combinational.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one registered ALU between two requesters, one operation in flight.
// Optional per-requester grant counters under ALU_ARB_STATS_EN.
module alu_req_arbiter
    import alu_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [DATA_W-1:0] req0_din,
    input  logic [DATA_W-1:0] req1_din,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_flags,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [DATA_W-1:0] alu_din,
    input  logic [DATA_W-1:0] alu_ans,
    input  logic [1:0]        alu_flag,
    output logic              busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1
`endif
);

    state_t   state_q;
    state_t   state_d;
    logic     last_grant_q;
    logic [1:0] gnt;
    logic     hs_c;
    logic     grant_id_c;
    alu_req_t req_sel_c;

    rr_arb2 u_rr_arb2 (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .gnt        (gnt)
    );

    assign grant_id_c = gnt[1];

    always_comb begin
        req_sel_c = grant_id_c ? '{op: req1_op, a: req1_a, b: req1_b, din: req1_din}
                               : '{op: req0_op, a: req0_a, b: req0_b, din: req0_din};
    end

    // Next state and the combinational request accept
    always_comb begin
        state_d   = state_q;
        req_ready = 2'b00;
        hs_c      = 1'b0;
        case (state_q)
            IDLE: begin
                if (reset) begin
                    req_ready = gnt;
                    hs_c      = |gnt;
                end
                if (hs_c) state_d = EXEC;
            end
            EXEC: state_d = CAPT;
            CAPT: state_d = RESP;
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // The alu_a/b/din registers double as the operand registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_data     <= '0;
            rsp_flags    <= 2'b00;
            alu_op       <= HOLD_OP;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_din      <= '0;
            busy         <= 1'b0;
        end else begin
            rsp_valid <= (state_d == RESP);
            busy      <= (state_d != IDLE);
            if (hs_c) begin
                last_grant_q <= grant_id_c;
                alu_op       <= req_sel_c.op;
                alu_a        <= req_sel_c.a;
                alu_b        <= req_sel_c.b;
                alu_din      <= req_sel_c.din;
            end
            // flag_ex is only meaningful while the operands are applied
            if (state_q == EXEC) begin
                alu_op    <= HOLD_OP;
                rsp_flags <= alu_flag;
            end
            if (state_q == CAPT) begin
                rsp_data <= alu_ans;
                rsp_id   <= last_grant_q;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            grant_cnt0 <= 16'h0000;
            grant_cnt1 <= 16'h0000;
        end else if (hs_c) begin
            if (grant_id_c) grant_cnt1 <= grant_cnt1 + 16'h0001;
            else            grant_cnt0 <= grant_cnt0 + 16'h0001;
        end
    end
`endif

endmodule
